// File: rtl/lfsr_seq_if.sv
// Job configuration and word readout handshakes between the host side and lfsr_seq_ctrl.
// The master modport is the host; the slave modport is the controller.
interface lfsr_seq_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned WORD  = 8,
    parameter int unsigned CNT_W = 8
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [WIDTH-1:0] cfg_tap;
    logic [WIDTH-1:0] cfg_seed;
    logic [CNT_W-1:0] cfg_words;
    logic [WORD-1:0]  word_data;
    logic             word_valid;
    logic             word_ready;

    modport master (
        output cfg_valid, cfg_tap, cfg_seed, cfg_words, word_ready,
        input  cfg_ready, word_data, word_valid
    );

    modport slave (
        input  cfg_valid, cfg_tap, cfg_seed, cfg_words, word_ready,
        output cfg_ready, word_data, word_valid
    );
endinterface

// File: rtl/lfsr_seq_ctrl.sv
// Job controller for a programmable LFSR: loads tap/seed, steps the LFSR one bit per cycle
// and packs the serial stream MSB-first into words handed out over a valid/ready handshake.
module lfsr_seq_ctrl #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned WORD  = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    lfsr_seq_if.slave        bus,
    input  logic             abort,
    output logic             lfsr_rst,
    output logic             lfsr_en,
    output logic [WIDTH-1:0] lfsr_tap,
    output logic [WIDTH-1:0] lfsr_seed,
    input  logic             lfsr_bit,
    output logic             busy,
    output logic             done,
    output logic             err
);
    localparam int unsigned BC_W = (WORD > 1) ? $clog2(WORD) : 1;

    typedef enum logic [2:0] {StIdle, StLoad, StRun, StHold, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] tap_q, tap_d;
    logic [WIDTH-1:0] seed_q, seed_d;
    logic [CNT_W-1:0] words_left_q, words_left_d;
    logic [BC_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [WORD-2:0]  shreg_q, shreg_d;
    logic [WORD-1:0]  word_data_q, word_data_d;
    logic             word_valid_q, word_valid_d;
    logic             err_q, err_d;
    logic             cfg_hs, word_hs;

    assign cfg_hs  = bus.cfg_valid && (state_q == StIdle);
    assign word_hs = word_valid_q && bus.word_ready;

    always_comb begin
        state_d      = state_q;
        tap_d        = tap_q;
        seed_d       = seed_q;
        words_left_d = words_left_q;
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        word_data_d  = word_data_q;
        word_valid_d = word_valid_q;
        err_d        = err_q;

        case (state_q)
            StIdle: begin
                if (cfg_hs) begin
                    tap_d        = bus.cfg_tap;
                    seed_d       = bus.cfg_seed;
                    words_left_d = bus.cfg_words;
                    // A zero seed locks the LFSR at zero, so it is rejected before anything else.
                    if (bus.cfg_seed == '0) begin
                        err_d   = 1'b1;
                        state_d = StDone;
                    end else begin
                        err_d   = 1'b0;
                        state_d = (bus.cfg_words == '0) ? StDone : StLoad;
                    end
                end
            end
            StLoad: begin
                bit_cnt_d = '0;
                state_d   = StRun;
            end
            StRun: begin
                shreg_d   = {shreg_q[WORD-3:0], lfsr_bit};
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (bit_cnt_q == BC_W'(WORD - 1)) begin
                    word_data_d  = {shreg_q, lfsr_bit};
                    word_valid_d = 1'b1;
                    words_left_d = words_left_q - 1'b1;
                    state_d      = StHold;
                end
            end
            StHold: begin
                if (word_hs) begin
                    word_valid_d = 1'b0;
                    if (words_left_q == '0) begin
                        state_d = StDone;
                    end else begin
                        bit_cnt_d = '0;
                        state_d   = StRun;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (abort && (state_q inside {StLoad, StRun, StHold})) begin
            state_d      = StDone;
            err_d        = 1'b0;
            word_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            tap_q        <= '0;
            seed_q       <= '0;
            words_left_q <= '0;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            word_data_q  <= '0;
            word_valid_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            tap_q        <= tap_d;
            seed_q       <= seed_d;
            words_left_q <= words_left_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            word_data_q  <= word_data_d;
            word_valid_q <= word_valid_d;
            err_q        <= err_d;
        end
    end

    assign bus.cfg_ready  = (state_q == StIdle);
    assign bus.word_data  = word_data_q;
    assign bus.word_valid = word_valid_q;
    assign busy           = (state_q != StIdle);
    assign done           = (state_q == StDone);
    assign lfsr_rst       = (state_q == StLoad);
    assign lfsr_en        = (state_q == StRun);
    assign lfsr_tap       = tap_q;
    assign lfsr_seed      = seed_q;
    assign err            = err_q;
endmodule
